// File: rtl/lift_pkg.sv
// lift_pkg: controller state codes, default floor count and the travel-timer FSM states
package lift_pkg;
  localparam logic [31:0] STATE_DOOR_OPEN  = 32'd1;
  localparam logic [31:0] STATE_DOOR_CLOSE = 32'd2;
  localparam logic [31:0] STATE_READY      = 32'd3;
  localparam logic [31:0] STATE_MOVE_UP    = 32'd4;
  localparam logic [31:0] STATE_MOVE_DOWN  = 32'd5;
  localparam int DEFAULT_NUM_FLOORS = 11;
  typedef enum logic [1:0] {IDLE, TRAVEL, ARRIVED} timer_state_t;
endpackage

// File: rtl/lift_floor_counter.sv
// lift_floor_counter: modulo-CYCLES counter with clear/enable and a terminal-count pulse
module lift_floor_counter #(
  parameter int CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1;
  logic [W-1:0] cnt;
  assign tc = en && cnt == W'(CYCLES - 1);
  // count enabled cycles, wrapping to zero on terminal count
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + W'(1);
endmodule

// File: rtl/lift_travel_timer.sv
// lift_travel_timer: models car travel per floor and pulses reached when the target floor is hit
module lift_travel_timer
  import lift_pkg::*;
#(
  parameter int CYCLES_PER_FLOOR = 8,
  parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
  parameter int FLOOR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        current_state,
  input  logic [31:0]        nfloor,
  input  logic [31:0]        pfloor,
  output logic               reached,
  output logic [FLOOR_W-1:0] car_floor,
  output logic               moving,
  output logic               travel_dir,
  output logic               fault
);
  timer_state_t state;
  logic tc, match, at_limit, is_up, is_move;
  logic [FLOOR_W-1:0] step_floor;
  logic [31:0] car32, step32;
  assign is_up = current_state == STATE_MOVE_UP;
  assign is_move = is_up || current_state == STATE_MOVE_DOWN;
  assign match = current_state == (travel_dir ? STATE_MOVE_UP : STATE_MOVE_DOWN);
  assign at_limit = travel_dir ? car_floor == FLOOR_W'(NUM_FLOORS - 1) : car_floor == '0;
  assign step_floor = travel_dir ? car_floor + FLOOR_W'(1) : car_floor - FLOOR_W'(1);
  assign car32 = 32'(car_floor);
  assign step32 = 32'(step_floor);
  lift_floor_counter #(.CYCLES(CYCLES_PER_FLOOR)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state != TRAVEL || !match),
    .en(state == TRAVEL),
    .tc(tc)
  );
  // travel FSM; the car floor register is the authoritative position
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      car_floor <= '0;
      reached <= 1'b0;
      moving <= 1'b0;
      travel_dir <= 1'b1;
      fault <= 1'b0;
    end else begin
      reached <= 1'b0;
      case (state)
        IDLE:
          if (is_move) begin
            if (nfloor >= 32'(NUM_FLOORS)) fault <= 1'b1;
            else begin
              if (pfloor != car32) fault <= 1'b1;
              if (nfloor == car32) begin
                state <= ARRIVED;
                reached <= 1'b1;
              end else if (is_up == (nfloor > car32)) begin
                state <= TRAVEL;
                moving <= 1'b1;
                travel_dir <= is_up;
              end else begin
                fault <= 1'b1;
                state <= ARRIVED;
                reached <= 1'b1;
              end
            end
          end
        TRAVEL:
          if (!match) begin
            fault <= 1'b1;
            state <= IDLE;
            moving <= 1'b0;
          end else if (tc) begin
            if (at_limit) begin
              fault <= 1'b1;
              state <= ARRIVED;
              reached <= 1'b1;
              moving <= 1'b0;
            end else begin
              car_floor <= step_floor;
              if (nfloor == step32 || (travel_dir ? nfloor < step32 : nfloor > step32)) begin
                fault <= fault | (nfloor != step32);
                state <= ARRIVED;
                reached <= 1'b1;
                moving <= 1'b0;
              end
            end
          end
        ARRIVED: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_lift_travel_timer.sv
// tb_lift_travel_timer: directed vector table plus hand sequences for the travel timer
module tb_lift_travel_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] cs = 32'd3, nf = 32'd0, pf = 32'd0;
  logic reached, moving, travel_dir, fault;
  logic [3:0] car_floor;
  int checks = 0, errors = 0;

  lift_travel_timer #(.CYCLES_PER_FLOOR(8), .NUM_FLOORS(11), .FLOOR_W(4)) dut (
    .clk(clk), .rst(rst), .current_state(cs), .nfloor(nf), .pfloor(pf),
    .reached(reached), .car_floor(car_floor), .moving(moving),
    .travel_dir(travel_dir), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit do_rst;
    logic [31:0] cs, nf, pf;
    int lat;
    logic [3:0] floor;
    bit dir, flt;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cs = 32'd3; nf = 32'd0; pf = 32'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic measure(output int lat);
    @(posedge clk); #1;
    lat = 0;
    while (!reached && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    bit ok_mov, ok_rch;
    vecs[0] = '{1, 32'd4, 32'd3,  32'd0,  24, 4'd3,  1, 0};
    vecs[1] = '{0, 32'd5, 32'd0,  32'd3,  24, 4'd0,  0, 0};
    vecs[2] = '{0, 32'd4, 32'd0,  32'd0,  0,  4'd0,  0, 0};
    vecs[3] = '{0, 32'd4, 32'd10, 32'd0,  80, 4'd10, 1, 0};
    vecs[4] = '{0, 32'd5, 32'd9,  32'd10, 8,  4'd9,  0, 0};
    vecs[5] = '{0, 32'd4, 32'd9,  32'd9,  0,  4'd9,  0, 0};
    vecs[6] = '{0, 32'd4, 32'd4,  32'd9,  0,  4'd9,  0, 1};
    vecs[7] = '{1, 32'd4, 32'd4,  32'd2,  32, 4'd4,  1, 1};
    vecs[8] = '{1, 32'd5, 32'd3,  32'd0,  0,  4'd0,  1, 1};

    do_reset();
    #1;
    chk("rst_reached", reached, 0);
    chk("rst_car_floor", car_floor, 0);
    chk("rst_moving", moving, 0);
    chk("rst_dir", travel_dir, 1);
    chk("rst_fault", fault, 0);

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      @(negedge clk);
      cs = vecs[i].cs; nf = vecs[i].nf; pf = vecs[i].pf;
      measure(lat);
      cs = 32'd3;
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_car_floor", i), car_floor, vecs[i].floor);
      chk($sformatf("v%0d_dir", i), travel_dir, vecs[i].dir);
      chk($sformatf("v%0d_fault", i), fault, vecs[i].flt);
      chk($sformatf("v%0d_moving_at_arrival", i), moving, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_pulse_end", i), reached, 0);
    end

    do_reset();
    @(negedge clk);
    cs = 32'd4; nf = 32'd3; pf = 32'd0;
    ok_mov = 1; ok_rch = 1;
    for (int e = 0; e <= 24; e++) begin
      @(posedge clk); #1;
      if (e < 24 && (!moving || reached)) begin ok_mov = ok_mov && moving; ok_rch = ok_rch && !reached; end
      if (e == 7 || e == 8 || e == 16 || e == 24) chk($sformatf("seq1_floor_e%0d", e), car_floor, e / 8);
      if (e == 24) begin
        chk("seq1_reached_e24", reached, 1);
        cs = 32'd3;
      end
    end
    chk("seq1_moving_throughout", ok_mov, 1);
    chk("seq1_no_early_reached", ok_rch, 1);
    chk("seq1_fault", fault, 0);

    do_reset();
    @(negedge clk);
    cs = 32'd4; nf = 32'd2; pf = 32'd0;
    for (int e = 0; e <= 10; e++) begin @(posedge clk); #1; end
    nf = 32'd5;
    lat = 10;
    while (!reached && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    cs = 32'd3;
    chk("retarget_latency", lat, 40);
    chk("retarget_floor", car_floor, 5);
    chk("retarget_fault", fault, 0);

    do_reset();
    @(negedge clk);
    cs = 32'd4; nf = 32'd11; pf = 32'd0;
    ok_rch = 1; ok_mov = 1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (reached) ok_rch = 0;
      if (moving) ok_mov = 0;
    end
    cs = 32'd3;
    chk("range_fault", fault, 1);
    chk("range_no_reached", ok_rch, 1);
    chk("range_no_motion", ok_mov, 1);
    chk("range_floor", car_floor, 0);

    do_reset();
    @(negedge clk);
    cs = 32'd4; nf = 32'd6; pf = 32'd0;
    for (int e = 0; e <= 12; e++) begin @(posedge clk); #1; end
    cs = 32'd3;
    ok_rch = 1;
    for (int e = 13; e < 40; e++) begin
      @(posedge clk); #1;
      if (reached) ok_rch = 0;
    end
    chk("abort_floor", car_floor, 1);
    chk("abort_fault", fault, 1);
    chk("abort_moving", moving, 0);
    chk("abort_no_reached", ok_rch, 1);
    do_reset();
    #1;
    chk("abort_rst_floor", car_floor, 0);
    chk("abort_rst_fault", fault, 0);
    chk("abort_rst_dir", travel_dir, 1);
    chk("abort_rst_moving", moving, 0);
    chk("abort_rst_reached", reached, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
